// File: rtl/cache_refill_ctrl_pkg.sv
// Shared definitions for the data-cache line refill controller: state encodings,
// line geometry and the cache-side flag constants.
package cache_refill_ctrl_pkg;

  typedef enum logic [1:0] {
    REFILL_IDLE    = 2'd0,
    REFILL_FILL    = 2'd1,
    REFILL_INSTALL = 2'd2,
    REFILL_SETTLE  = 2'd3
  } refill_state_e;

  localparam int LINE_WORDS_C     = 8;
  localparam int LINE_OFFSET_BITS = 5;
  localparam int WORD_OFFSET_BITS = 2;

  localparam int CACHE_LINE_W  = 256;
  localparam int DATA_ADDR_BUS = 32;

  localparam logic UPDATE     = 1'b1;
  localparam logic NOT_UPDATE = 1'b0;
  localparam logic MISS       = 1'b1;
  localparam logic NOT_MISS   = 1'b0;

endpackage

// File: rtl/cache_refill_ctrl_line_buf.sv
// Line assembly buffer: LINE_WORDS x WORD_W registers, one write port,
// asynchronous clear, whole line exposed flat with word k at [k*WORD_W +: WORD_W].
module refill_line_buf #(
  parameter int WORD_W     = 32,
  parameter int LINE_WORDS = 8,
  parameter int IDX_W      = $clog2(LINE_WORDS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         we,
  input  logic [IDX_W-1:0]             idx,
  input  logic [WORD_W-1:0]            wdata,
  output logic [WORD_W*LINE_WORDS-1:0] line
);

  logic [WORD_W-1:0] words_q [LINE_WORDS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < LINE_WORDS; k++) words_q[k] <= '0;
    end else if (we) begin
      words_q[idx] <= wdata;
    end
  end

  always_comb begin
    line = '0;
    for (int k = 0; k < LINE_WORDS; k++) line[k*WORD_W +: WORD_W] = words_q[k];
  end

endmodule

// File: rtl/cache_refill_ctrl.sv
// Data-cache line refill controller: fetches a full line word by word from main
// memory, then strobes it into the cache. CACHE_REFILL_CWF_EN enables critical-word-first.
module cache_refill_ctrl
  import cache_refill_ctrl_pkg::*;
#(
  parameter int ADDR_W     = DATA_ADDR_BUS,
  parameter int WORD_W     = 32,
  parameter int LINE_WORDS = LINE_WORDS_C,
  parameter int LINE_W     = WORD_W * LINE_WORDS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_rd_en,
  input  logic              cpu_wr_en,
  input  logic              miss,
  output logic              stall,
  output logic              refill_busy,
  output logic [ADDR_W-1:0] refill_addr,
  output logic [LINE_W-1:0] update_data,
  output logic              update_en,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [WORD_W-1:0] mem_rdata,
  input  logic              mem_ack,
`ifdef CACHE_REFILL_CWF_EN
  output logic              crit_valid,
  output logic [WORD_W-1:0] crit_data,
`endif
  output refill_state_e     dbg_state
);

  localparam int IDX_W = $clog2(LINE_WORDS);
  localparam int LOFF  = $clog2(LINE_W / 8);
  localparam int WOFF  = $clog2(WORD_W / 8);

  refill_state_e         state_q, state_d;
  logic [IDX_W-1:0]      beat_idx_q, beat_cnt_q, start_beat;
  logic [ADDR_W-1:0]     refill_addr_q;
  logic [IDX_W+WOFF-1:0] beat_off;
  logic                  req_hit, beat_ack, last_beat;
  logic                  addr_unused;

  assign req_hit   = (miss == MISS) & (cpu_rd_en | cpu_wr_en);
  assign beat_ack  = (state_q == REFILL_FILL) & mem_ack;
  assign last_beat = (beat_cnt_q == IDX_W'(LINE_WORDS - 1));
  assign beat_off  = {beat_idx_q, {WOFF{1'b0}}};
  assign addr_unused = ^cpu_addr[LOFF-1:0];

`ifdef CACHE_REFILL_CWF_EN
  assign start_beat = cpu_addr[LOFF-1:WOFF];
  assign crit_valid = beat_ack & (beat_cnt_q == '0);
  assign crit_data  = crit_valid ? mem_rdata : '0;
`else
  assign start_beat = '0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= REFILL_IDLE;
      beat_idx_q    <= '0;
      beat_cnt_q    <= '0;
      refill_addr_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == REFILL_IDLE && req_hit) begin
        refill_addr_q <= {cpu_addr[ADDR_W-1:LOFF], {LOFF{1'b0}}};
        beat_idx_q    <= start_beat;
        beat_cnt_q    <= '0;
      end else if (beat_ack) begin
        beat_idx_q <= beat_idx_q + 1'b1;
        beat_cnt_q <= beat_cnt_q + 1'b1;
      end
    end
  end

  // Memory handshake: mem_req/mem_addr are held stable until mem_ack; a beat
  // transfers in any cycle where mem_req & mem_ack, and mem_rdata is valid then.
  always_comb begin
    state_d   = state_q;
    mem_req   = 1'b0;
    update_en = NOT_UPDATE;
    case (state_q)
      REFILL_IDLE:    if (req_hit) state_d = REFILL_FILL;
      REFILL_FILL: begin
        mem_req = 1'b1;
        if (mem_ack && last_beat) state_d = REFILL_INSTALL;
      end
      REFILL_INSTALL: begin
        update_en = UPDATE;
        state_d   = REFILL_SETTLE;
      end
      REFILL_SETTLE:  state_d = REFILL_IDLE;
      default:        state_d = REFILL_IDLE;
    endcase
  end

  assign mem_addr    = mem_req ? (refill_addr_q + ADDR_W'(beat_off)) : '0;
  assign refill_busy = (state_q != REFILL_IDLE);
  assign stall       = refill_busy | req_hit;
  assign refill_addr = refill_addr_q;
  assign dbg_state   = state_q;

  refill_line_buf #(
    .WORD_W     (WORD_W),
    .LINE_WORDS (LINE_WORDS),
    .IDX_W      (IDX_W)
  ) u_line_buf (
    .clk   (clk),
    .rst   (rst),
    .we    (beat_ack),
    .idx   (beat_idx_q),
    .wdata (mem_rdata),
    .line  (update_data)
  );

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed bench for cache_refill_ctrl: a table of per-cycle vectors for the basic
// refill plus hand-written sequences for slow memory, reset, held miss and CWF order.
module tb_cache_refill_ctrl;
  import cache_refill_ctrl_pkg::*;

  localparam int ADDR_W = 32;
  localparam int WORD_W = 32;
  localparam int LINE_W = 256;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic              cpu_rd_en = 1'b0;
  logic              cpu_wr_en = 1'b0;
  logic              miss = 1'b0;
  logic              stall, refill_busy, update_en, mem_req;
  logic [ADDR_W-1:0] refill_addr, mem_addr;
  logic [LINE_W-1:0] update_data;
  logic [WORD_W-1:0] mem_rdata = '0;
  logic              mem_ack = 1'b0;
  refill_state_e     dbg_state;
`ifdef CACHE_REFILL_CWF_EN
  logic              crit_valid;
  logic [WORD_W-1:0] crit_data;
`endif

  cache_refill_ctrl dut (
    .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_rd_en(cpu_rd_en),
    .cpu_wr_en(cpu_wr_en), .miss(miss), .stall(stall), .refill_busy(refill_busy),
    .refill_addr(refill_addr), .update_data(update_data), .update_en(update_en),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
`ifdef CACHE_REFILL_CWF_EN
    .crit_valid(crit_valid), .crit_data(crit_data),
`endif
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- memory responder ----------------
  int          ack_gap = 0;
  int          gap_cnt = 0;
  logic        man_ack = 1'b0;
  logic [31:0] man_rdata = '0;

  always @(negedge clk) begin
    if (ack_gap != 0 && mem_req) begin
      if (gap_cnt == ack_gap - 1) begin
        mem_ack   = 1'b1;
        mem_rdata = 32'hA000_0000 + mem_addr;
        gap_cnt   = 0;
      end else begin
        mem_ack = 1'b0;
        gap_cnt = gap_cnt + 1;
      end
    end else begin
      mem_ack   = man_ack;
      mem_rdata = man_rdata;
      gap_cnt   = 0;
    end
  end

  // ---------------- scoreboard ----------------
  int          n_pass = 0;
  int          n_total = 0;
  logic [31:0] exp_q[$];
  int          crit_n = 0;
  logic [31:0] crit_word = '0;

  task automatic check(input string name, input logic [LINE_W-1:0] act,
                       input logic [LINE_W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  function automatic logic [LINE_W-1:0] exp_line(input logic [31:0] base);
    logic [LINE_W-1:0] l;
    l = '0;
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = 32'hA000_0000 + base + 32'(4 * k);
    return l;
  endfunction

  task automatic run_refill(input logic [31:0] addr, input int gap,
                            output int stall_n, output int ack_n, output int upd_n);
    ack_gap = gap;
    stall_n = 0; ack_n = 0; upd_n = 0; crit_n = 0;
    @(negedge clk);
    miss = 1'b1; cpu_rd_en = 1'b1; cpu_addr = addr;
    for (int c = 0; c < 200; c++) begin
      #1;
      if (!stall) break;
      stall_n++;
      if (mem_req && mem_ack) begin
        ack_n++;
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL extra_beat: got beat at %h want no further beat", mem_addr);
        end else begin
          check($sformatf("beat_addr%0d", ack_n), LINE_W'(mem_addr), LINE_W'(exp_q.pop_front()));
        end
      end
      if (update_en) upd_n++;
`ifdef CACHE_REFILL_CWF_EN
      if (crit_valid) begin
        crit_n++;
        crit_word = crit_data;
      end
`endif
      @(negedge clk);
      miss = 1'b0; cpu_rd_en = 1'b0;
    end
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic        miss;
    logic        rd_en;
    logic [31:0] cpu_addr;
    logic        exp_stall;
    logic        exp_busy;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_upd;
  } vec_t;

  vec_t vecs[12];

  int   s_n, a_n, u_n, acks, upd_seen;
  logic seen;

  initial begin
    vecs[0] = '{1'b1, 1'b1, 32'h1044, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0};
    for (int k = 1; k <= 8; k++)
      vecs[k] = '{1'b0, 1'b1, 32'h3000, 1'b1, 1'b1, 1'b1, 32'h1040 + 32'(4 * (k - 1)), 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 32'h3000, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 32'h3000, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 32'h0,    1'b0, 1'b0, 1'b0, 32'h0, 1'b0};

    // reset state
    #12;
    check("reset_outputs", LINE_W'({stall, refill_busy, mem_req, mem_addr, update_en, refill_addr}), '0);
    check("reset_line", update_data, '0);
    @(negedge clk); rst = 1'b1;

    // basic refill, ack every cycle, applied per cycle from the table
    ack_gap = 1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      miss = vecs[i].miss; cpu_rd_en = vecs[i].rd_en; cpu_addr = vecs[i].cpu_addr;
      #1;
      check($sformatf("vec%0d", i),
            LINE_W'({stall, refill_busy, mem_req, mem_addr, update_en}),
            LINE_W'({vecs[i].exp_stall, vecs[i].exp_busy, vecs[i].exp_req,
                     vecs[i].exp_addr, vecs[i].exp_upd}));
    end
    cpu_rd_en = 1'b0;
    check("basic_line", update_data, exp_line(32'h1040));
    check("basic_refill_addr", LINE_W'(refill_addr), LINE_W'(32'h1040));

    // spurious ack in IDLE must not touch the buffer
    ack_gap = 0;
    @(posedge clk); #2; man_ack = 1'b1; man_rdata = 32'hDEAD_BEEF;
    @(posedge clk); @(posedge clk); #2; man_ack = 1'b0;
    @(negedge clk); #1;
    check("spurious_ack_line", update_data, exp_line(32'h1040));
    check("spurious_ack_busy", LINE_W'(refill_busy), '0);

    // miss held through SETTLE, then a new line in the following cycle
    ack_gap = 1;
    @(negedge clk); miss = 1'b1; cpu_rd_en = 1'b1; cpu_addr = 32'h1044;
    seen = 1'b0;
    for (int c = 0; c < 30 && !seen; c++) begin
      #1;
      if (update_en) seen = 1'b1;
      else @(negedge clk);
    end
    check("held_miss_install", LINE_W'(seen), LINE_W'(1'b1));
    @(negedge clk); #1;
    check("held_miss_settle", LINE_W'({dbg_state, stall}), LINE_W'({REFILL_SETTLE, 1'b1}));
    @(negedge clk); cpu_addr = 32'h2000; #1;
    check("after_settle_idle", LINE_W'({refill_busy, stall}), LINE_W'(2'b01));
    @(negedge clk); miss = 1'b0; cpu_rd_en = 1'b0; #1;
    check("new_miss_fill", LINE_W'({mem_req, mem_addr}), LINE_W'({1'b1, 32'h2000}));
    for (int c = 0; c < 40; c++) begin
      if (!stall) break;
      @(negedge clk); #1;
    end
    check("new_miss_done", LINE_W'(stall), '0);
    check("new_miss_line", update_data, exp_line(32'h2000));

    // slow memory: ack every third cycle
    for (int k = 0; k < 8; k++) exp_q.push_back(32'h1040 + 32'(4 * k));
    run_refill(32'h1044, 3, s_n, a_n, u_n);
    check("slow_stall_len", LINE_W'(s_n), LINE_W'(27));
    check("slow_acks", LINE_W'(a_n), LINE_W'(8));
    check("slow_update_cnt", LINE_W'(u_n), LINE_W'(1));
    check("slow_line", update_data, exp_line(32'h1040));
    exp_q.delete();

    // asynchronous reset after four beats
    ack_gap = 1; acks = 0; upd_seen = 0;
    @(negedge clk); miss = 1'b1; cpu_rd_en = 1'b1; cpu_addr = 32'h1044;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (mem_req && mem_ack) acks++;
      if (update_en) upd_seen++;
      if (acks == 4) break;
      @(negedge clk); miss = 1'b0; cpu_rd_en = 1'b0;
    end
    miss = 1'b0; cpu_rd_en = 1'b0;
    check("rst_acks_before", LINE_W'(acks), LINE_W'(4));
    @(posedge clk); #3; rst = 1'b0; #1;
    check("rst_async_outputs", LINE_W'({mem_req, refill_busy, update_en}), '0);
    check("rst_async_line", update_data, '0);
    @(negedge clk); @(negedge clk); rst = 1'b1;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk); #1;
      if (update_en) upd_seen++;
    end
    check("rst_no_update", LINE_W'(upd_seen), '0);
    check("rst_after_release", LINE_W'({refill_busy, update_data}), '0);

    // miss at a mid-line word: order depends on critical-word-first
`ifdef CACHE_REFILL_CWF_EN
    for (int k = 0; k < 8; k++) exp_q.push_back(32'h1040 + 32'(4 * ((k + 6) % 8)));
`else
    for (int k = 0; k < 8; k++) exp_q.push_back(32'h1040 + 32'(4 * k));
`endif
    run_refill(32'h1058, 1, s_n, a_n, u_n);
    check("mid_stall_len", LINE_W'(s_n), LINE_W'(11));
    check("mid_update_cnt", LINE_W'(u_n), LINE_W'(1));
    check("mid_line", update_data, exp_line(32'h1040));
    check("mid_refill_addr", LINE_W'(refill_addr), LINE_W'(32'h1040));
`ifdef CACHE_REFILL_CWF_EN
    check("crit_pulses", LINE_W'(crit_n), LINE_W'(1));
    check("crit_word", LINE_W'(crit_word), LINE_W'(32'hA000_1058));
`endif
    exp_q.delete();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
